// File: rtl/hex_ascii_pkg.sv
// Shared types and ASCII constants for the hex word sender.
// Imported by the character converter and the sender FSM.
package hex_ascii_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACCEPT,
    DRAIN
  } hex_tx_state_t;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_UA   = 8'h41;
  localparam logic [7:0] ASCII_LA   = 8'h61;

endpackage

// File: rtl/hex_to_char.sv
// Nibble to ASCII hex digit, the counterpart of the receive-side
// character-to-hex decoder.
module hex_to_char
  import hex_ascii_pkg::*;
#(
  parameter bit UPPERCASE = 1'b1
) (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_char
);

  logic [7:0] w_n;
  logic [7:0] w_alpha;

  assign w_n     = {4'h0, i_nibble};
  assign w_alpha = UPPERCASE ? ASCII_UA : ASCII_LA;

  always_comb begin
    o_char = ASCII_ZERO + w_n;
    unique case (1'b1)
      (i_nibble < 4'd10): o_char = ASCII_ZERO + w_n;
      default:            o_char = w_alpha + w_n - 8'd10;
    endcase
  end

endmodule

// File: rtl/hex_word_sender.sv
// Prints a word as ASCII hex (MSB nibble first, optional CR LF)
// through a UART transmitter's newData/dataIn/done handshake.
module hex_word_sender
  import hex_ascii_pkg::*;
#(
  parameter int NIBBLES     = 4,
  parameter bit UPPERCASE   = 1'b1,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   word,
  output logic                   busy,
  output logic                   done,
  output logic                   tx_new,
  output logic [7:0]             tx_data,
  input  logic                   tx_done
);

  localparam int W  = 4 * NIBBLES;
  localparam int N  = NIBBLES + (APPEND_CRLF ? 2 : 0);
  localparam int IW = $clog2(NIBBLES + 2);

  localparam logic [IW-1:0] DIGITS = IW'(NIBBLES);
  localparam logic [IW-1:0] LAST   = IW'(N - 1);

  hex_tx_state_t r_state;
  logic [W-1:0]  r_word;
  logic [IW-1:0] r_idx;
  logic          r_busy;
  logic          r_done;
  logic          r_tx_new;
  logic [7:0]    r_tx_data;

  logic [7:0]    w_hex;
  logic [7:0]    w_char;

  // The latched word shifts left as digits go out, so the
  // converter always looks at the top nibble.
  hex_to_char #(
    .UPPERCASE (UPPERCASE)
  ) u_h2c (
    .i_nibble (r_word[W-1 -: 4]),
    .o_char   (w_hex)
  );

  always_comb begin
    w_char = ASCII_LF;
    unique case (1'b1)
      (r_idx < DIGITS):  w_char = w_hex;
      (r_idx == DIGITS): w_char = ASCII_CR;
      default:           w_char = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_word    <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tx_new  <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_word  <= word;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (tx_done) begin
            r_tx_new  <= 1'b1;
            r_tx_data <= w_char;
            if (r_idx < DIGITS) begin
              r_word <= r_word << 4;
            end
            r_state <= ACCEPT;
          end
        end
        ACCEPT: begin
          r_tx_new <= 1'b0;
          if (!tx_done) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (tx_done) begin
            if (r_idx == LAST) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_state <= LOAD;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign tx_new  = r_tx_new;
  assign tx_data = r_tx_data;

endmodule

// File: tb/tb_hex_word_sender.sv
// Two senders (default and 2-digit lowercase no-CRLF) each driving
// a registered transmitter model; checked against a text-level model.
module tb_hex_word_sender;

  localparam int TXC = 12;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  st    = 2'b00;
  logic [1:0]  frc   = 2'b00;
  logic [1:0]  txd   = 2'b11;
  logic [1:0]  bz;
  logic [1:0]  dn;
  logic [1:0]  tn;
  logic [7:0]  td0;
  logic [7:0]  td1;
  logic [15:0] word0 = 16'h0;
  logic [7:0]  word1 = 8'h0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hex_word_sender u_dut0 (
    .clk     (clk),
    .reset_n (rst_n),
    .start   (st[0]),
    .word    (word0),
    .busy    (bz[0]),
    .done    (dn[0]),
    .tx_new  (tn[0]),
    .tx_data (td0),
    .tx_done (txd[0])
  );

  hex_word_sender #(
    .NIBBLES     (2),
    .UPPERCASE   (1'b0),
    .APPEND_CRLF (1'b0)
  ) u_dut1 (
    .clk     (clk),
    .reset_n (rst_n),
    .start   (st[1]),
    .word    (word1),
    .busy    (bz[1]),
    .done    (dn[1]),
    .tx_new  (tn[1]),
    .tx_data (td1),
    .tx_done (txd[1])
  );

  function automatic logic [7:0] tdx(input int u);
    return (u == 0) ? td0 : td1;
  endfunction

  task automatic chk_eq(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_true(input string nm, input bit cond);
    n_chk++;
    if (!cond) begin
      n_fail++;
      $display("FAIL %s: condition false at %0t", nm, $time);
    end
  endtask

  // Transmitter model: takes a byte when idle, busy TXC cycles.
  logic [7:0] rxb [2][0:63];
  int         rn  [2] = '{0, 0};
  int         cnt [2] = '{0, 0};

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (tn[u] && txd[u]) begin
        if (rn[u] < 64) rxb[u][rn[u]] <= tdx(u);
        rn[u]  <= rn[u] + 1;
        cnt[u] <= TXC;
        txd[u] <= 1'b0;
      end else if (cnt[u] > 1) begin
        cnt[u] <= cnt[u] - 1;
      end else begin
        cnt[u] <= 0;
        txd[u] <= !frc[u];
      end
    end
  end

  // Reference model: expected character stream per accepted word.
  logic [7:0] eq [2][0:31];
  int         eh [2] = '{0, 0};
  int         et [2] = '{0, 0};
  int         stg[2] = '{0, 0};
  bit         mb [2] = '{1'b0, 1'b0};
  logic [7:0] md [2] = '{8'h00, 8'h00};
  int         dcount[2] = '{0, 0};
  int         ntn[2] = '{0, 0};
  logic [1:0] p_txd = 2'b11;
  logic [1:0] p_tn  = 2'b00;

  task automatic push(input int u, input logic [7:0] c);
    eq[u][et[u] % 32] = c;
    et[u]++;
  endtask

  task automatic enq(input int u, input logic [15:0] w);
    int n;
    int d;
    logic [7:0] c;
    n = (u == 0) ? 4 : 2;
    for (int i = 0; i < n; i++) begin
      d = int'((w >> (4 * (n - 1 - i))) & 16'hF);
      if (d < 10) c = 8'(48 + d);
      else        c = 8'(((u == 0) ? 65 : 97) + d - 10);
      push(u, c);
    end
    if (u == 0) begin
      push(u, 8'h0D);
      push(u, 8'h0A);
    end
  endtask

  always @(negedge clk) begin
    bit mb0;
    bit edn;
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        chk_eq("reset busy", bz[u], 0);
        chk_eq("reset done", dn[u], 0);
        chk_eq("reset tx_new", tn[u], 0);
        chk_eq("reset tx_data", tdx(u), 0);
        eh[u] = 0; et[u] = 0; stg[u] = 0;
        mb[u] = 1'b0; md[u] = 8'h00;
        p_tn[u] = 1'b0;
      end else begin
        mb0 = mb[u];
        edn = 1'b0;
        if (stg[u] == 1 && !p_txd[u]) begin
          stg[u] = 2;
        end else if (stg[u] == 2 && p_txd[u]) begin
          edn = 1'b1; stg[u] = 0; mb[u] = 1'b0;
        end
        if (!mb0 && st[u]) begin
          mb[u] = 1'b1;
          enq(u, (u == 0) ? word0 : {8'h00, word1});
        end
        chk_eq("done", dn[u], edn);
        if (dn[u]) dcount[u]++;
        chk_eq("busy", bz[u], mb[u]);
        if (tn[u]) begin
          ntn[u]++;
          chk_true("tx_new after tx_done high", p_txd[u]);
          chk_true("tx_new single pulse", !p_tn[u]);
          chk_true("tx_new expected", eh[u] != et[u]);
          if (eh[u] != et[u]) begin
            chk_eq("tx_data", tdx(u), eq[u][eh[u] % 32]);
            md[u] = eq[u][eh[u] % 32];
            eh[u]++;
            if (eh[u] == et[u]) stg[u] = 1;
          end
        end else begin
          chk_eq("tx_data hold", tdx(u), md[u]);
        end
        p_tn[u] = tn[u];
      end
      p_txd[u] = txd[u];
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(input int u, input logic [15:0] w);
    if (u == 0) word0 = w;
    else        word1 = w[7:0];
    st[u] = 1'b1;
    cyc(1);
    st[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, input int d0);
    for (int k = 0; k < 2000 && dcount[u] == d0; k++) cyc(1);
    chk_true("done within budget", dcount[u] != d0);
  endtask

  task automatic chk_rx(input int u, input int base, input logic [127:0] v, input int n);
    logic [127:0] vv;
    vv = v;
    chk_eq("rx count", rn[u] - base, n);
    for (int k = 0; k < n; k++) begin
      chk_eq($sformatf("rx byte %0d", k), rxb[u][base + k], vv[8 * (n - 1 - k) +: 8]);
    end
  endtask

  initial begin
    int base;
    int d0;
    int r;
    int s;
    cyc(3);
    chk_eq("reset tx_data0 literal", td0, 8'h00);
    chk_eq("reset busy0 literal", bz[0], 0);
    rst_n = 1'b1;
    cyc(2);

    // 1: default word, with start latency
    base = rn[0]; d0 = dcount[0];
    word0 = 16'h1A2F;
    st[0] = 1'b1;
    cyc(1);
    st[0] = 1'b0;
    chk_eq("latency cycle1 tx_new", tn[0], 0);
    chk_eq("busy after accept", bz[0], 1);
    cyc(1);
    chk_eq("latency cycle2 tx_new", tn[0], 1);
    chk_eq("first char", td0, 8'h31);
    wait_done(0, d0);
    chk_eq("busy in done cycle", bz[0], 0);
    cyc(3);
    chk_rx(0, base, 128'h3141_3246_0D0A, 6);
    chk_eq("one done word1", dcount[0] - d0, 1);

    // 2: lowercase, two digits, no CRLF
    base = rn[1]; d0 = dcount[1];
    send(1, 16'h00BE);
    wait_done(1, d0);
    cyc(3);
    chk_rx(1, base, 128'h6265, 2);
    chk_eq("one done be", dcount[1] - d0, 1);

    // 3: start held and re-pulsed while busy
    base = rn[0]; d0 = dcount[0];
    word0 = 16'h0000;
    st[0] = 1'b1;
    cyc(5);
    word0 = 16'hFFFF;
    cyc(3);
    st[0] = 1'b0;
    cyc(10);
    send(0, 16'hFFFF);
    wait_done(0, d0);
    cyc(2 * TXC + 10);
    chk_rx(0, base, 128'h3030_3030_0D0A, 6);
    chk_eq("one done held start", dcount[0] - d0, 1);

    // 4: transmitter busy at start
    frc[0] = 1'b1;
    cyc(2);
    base = rn[0]; d0 = dcount[0];
    send(0, 16'hC0DE);
    cyc(50);
    chk_eq("stall no bytes", rn[0] - base, 0);
    chk_eq("stall busy", bz[0], 1);
    frc[0] = 1'b0;
    r = -1; s = -1;
    for (int k = 0; k < 20 && s < 0; k++) begin
      cyc(1);
      if (txd[0] && r < 0) r = k;
      if (tn[0]) s = k;
    end
    chk_eq("tx_new one sample after tx_done seen", s - r, 1);
    wait_done(0, d0);
    cyc(3);
    chk_rx(0, base, 128'h4330_4445_0D0A, 6);

    // 5: reset during third character
    base = rn[0]; d0 = dcount[0];
    send(0, 16'h1234);
    for (int k = 0; k < 1000 && rn[0] < base + 3; k++) cyc(1);
    chk_true("third char reached", rn[0] >= base + 3);
    rst_n = 1'b0;
    #1;
    chk_eq("async reset busy", bz[0], 0);
    chk_eq("async reset done", dn[0], 0);
    chk_eq("async reset tx_new", tn[0], 0);
    chk_eq("async reset tx_data", td0, 8'h00);
    cyc(3);
    rst_n = 1'b1;
    for (int k = 0; k < 100 && !txd[0]; k++) cyc(1);
    cyc(2 * TXC);
    chk_eq("no bytes after reset", rn[0] - base, 3);
    chk_eq("no done after reset", dcount[0] - d0, 0);
    base = rn[0];
    send(0, 16'hABCD);
    wait_done(0, d0);
    cyc(3);
    chk_rx(0, base, 128'h4142_4344_0D0A, 6);

    // 6: back-to-back, second start in cycle after done
    base = rn[0]; d0 = dcount[0];
    send(0, 16'h0009);
    for (int k = 0; k < 2000 && !dn[0]; k++) cyc(1);
    chk_eq("done seen for 0009", dn[0], 1);
    word0 = 16'hF000;
    st[0] = 1'b1;
    cyc(1);
    st[0] = 1'b0;
    chk_eq("back-to-back accepted", bz[0], 1);
    wait_done(0, d0 + 1);
    cyc(3);
    chk_rx(0, base, 128'h3030_3039_0D0A_4630_3030_0D0A, 12);
    chk_eq("two dones back-to-back", dcount[0] - d0, 2);

    chk_eq("tx_new count vs bytes u0", ntn[0], rn[0]);
    chk_eq("tx_new count vs bytes u1", ntn[1], rn[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
